// File: rtl/polaris_gpio_pkg.sv
// rtl/polaris_gpio_pkg.sv - register map, TileLink opcodes and shared helpers for polaris_gpio_v2
package polaris_gpio_pkg;

    localparam logic [3:0] REG_IN       = 4'h0;
    localparam logic [3:0] REG_OUT      = 4'h1;
    localparam logic [3:0] REG_OUT_SET  = 4'h2;
    localparam logic [3:0] REG_OUT_CLR  = 4'h3;
    localparam logic [3:0] REG_OUT_TGL  = 4'h4;
    localparam logic [3:0] REG_OE       = 4'h5;
    localparam logic [3:0] REG_RISE_EN  = 4'h6;
    localparam logic [3:0] REG_FALL_EN  = 4'h7;
    localparam logic [3:0] REG_IRQ_PEND = 4'h8;
    localparam logic [3:0] REG_IRQ_MASK = 4'h9;
    localparam logic [3:0] REG_DEB_DIV  = 4'hA;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    localparam logic [15:0] DEB_DIV_RST = 16'h00FF;

    // Expands the 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/polaris_gpio_debounce.sv
// rtl/polaris_gpio_debounce.sv - shared prescaler and per-pin 3-sample input filter
// Built only when GPIO_DEBOUNCE_EN is defined.
module polaris_gpio_debounce
    import polaris_gpio_pkg::*;
#(
    parameter int NGPIO = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [15:0]      i_deb_div,
    input  logic [NGPIO-1:0] i_sync,
    output logic [NGPIO-1:0] o_filt
);

    logic [15:0]           r_cnt;
    logic                  w_tick;
    logic [NGPIO-1:0][2:0] r_samp;
    logic [NGPIO-1:0]      r_filt;

    assign w_tick = (r_cnt == 16'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= DEB_DIV_RST;
        end else if (w_tick) begin
            r_cnt <= i_deb_div;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // The filtered level only moves once three consecutive tick samples agree.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samp <= '0;
            r_filt <= '0;
        end else begin
            for (int i = 0; i < NGPIO; i++) begin
                if (w_tick) begin
                    r_samp[i] <= {r_samp[i][1:0], i_sync[i]};
                end
                if (r_samp[i] == 3'b111) begin
                    r_filt[i] <= 1'b1;
                end else if (r_samp[i] == 3'b000) begin
                    r_filt[i] <= 1'b0;
                end
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/polaris_gpio_v2.sv
// rtl/polaris_gpio_v2.sv - TileLink-UL GPIO controller with edge interrupts
// Optional input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module polaris_gpio_v2
    import polaris_gpio_pkg::*;
#(
    parameter int TL_RS       = 4,
    parameter int NGPIO       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             gpio_clock_i,
    input  logic             gpio_reset_i,
    input  logic [2:0]       gpio_a_opcode,
    input  logic [2:0]       gpio_a_param,
    input  logic [3:0]       gpio_a_size,
    input  logic [TL_RS-1:0] gpio_a_source,
    input  logic [5:0]       gpio_a_address,
    input  logic [3:0]       gpio_a_mask,
    input  logic [31:0]      gpio_a_data,
    input  logic             gpio_a_corrupt,
    input  logic             gpio_a_valid,
    output logic             gpio_a_ready,
    output logic [2:0]       gpio_d_opcode,
    output logic [1:0]       gpio_d_param,
    output logic [3:0]       gpio_d_size,
    output logic [TL_RS-1:0] gpio_d_source,
    output logic             gpio_d_denied,
    output logic [31:0]      gpio_d_data,
    output logic             gpio_d_corrupt,
    output logic             gpio_d_valid,
    input  logic             gpio_d_ready,
    output logic [NGPIO-1:0] outputs_o,
    output logic [NGPIO-1:0] t_o,
    input  logic [NGPIO-1:0] inputs_i,
    output logic             irq_o
);

    logic [SYNC_STAGES-1:0][NGPIO-1:0] r_sync;
    logic [NGPIO-1:0] w_sync;
    logic [NGPIO-1:0] w_in;
    logic [NGPIO-1:0] r_prev;
    logic [NGPIO-1:0] r_out;
    logic [NGPIO-1:0] r_oe;
    logic [NGPIO-1:0] r_rise_en;
    logic [NGPIO-1:0] r_fall_en;
    logic [NGPIO-1:0] r_pend;
    logic [NGPIO-1:0] r_mask;
    logic             r_irq;
    logic [2:0]       r_quiet;

    logic             r_d_valid;
    logic [2:0]       r_d_opcode;
    logic [3:0]       r_d_size;
    logic [TL_RS-1:0] r_d_source;
    logic             r_d_denied;
    logic [31:0]      r_d_data;

    logic             w_accept;
    logic             w_is_get;
    logic             w_is_put;
    logic             w_wr_en;
    logic [3:0]       w_word;
    logic [31:0]      w_lanes;
    logic [31:0]      w_wbits;
    logic [NGPIO-1:0] w_wl;
    logic [NGPIO-1:0] w_wb;
    logic [NGPIO-1:0] w_w1c;
    logic [NGPIO-1:0] w_edges;
    logic [31:0]      w_rdata;
    logic             w_unused;

    always_ff @(posedge gpio_clock_i) begin
        if (gpio_reset_i) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= inputs_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] r_deb_div;

    polaris_gpio_debounce #(
        .NGPIO (NGPIO)
    ) u_debounce (
        .i_clk     (gpio_clock_i),
        .i_rst     (gpio_reset_i),
        .i_deb_div (r_deb_div),
        .i_sync    (w_sync),
        .o_filt    (w_in)
    );
`else
    assign w_in = w_sync;
`endif

    assign gpio_a_ready = ~r_d_valid | gpio_d_ready;
    assign w_accept     = gpio_a_valid & gpio_a_ready;
    assign w_word       = gpio_a_address[5:2];
    assign w_is_get     = (gpio_a_opcode == GET);
    assign w_is_put     = (gpio_a_opcode == PUT_FULL) | (gpio_a_opcode == PUT_PARTIAL);
    assign w_wr_en      = w_accept & w_is_put;
    assign w_lanes      = lane_mask(gpio_a_mask);
    assign w_wbits      = gpio_a_data & w_lanes;
    assign w_wl         = w_lanes[NGPIO-1:0];
    assign w_wb         = w_wbits[NGPIO-1:0];
    assign w_w1c        = (w_wr_en && w_word == REG_IRQ_PEND) ? w_wb : '0;

    always_comb begin
        w_rdata = '0;
        case (w_word)
            REG_IN:       w_rdata = 32'(w_in);
            REG_OUT:      w_rdata = 32'(r_out);
            REG_OE:       w_rdata = 32'(r_oe);
            REG_RISE_EN:  w_rdata = 32'(r_rise_en);
            REG_FALL_EN:  w_rdata = 32'(r_fall_en);
            REG_IRQ_PEND: w_rdata = 32'(r_pend);
            REG_IRQ_MASK: w_rdata = 32'(r_mask);
`ifdef GPIO_DEBOUNCE_EN
            REG_DEB_DIV:  w_rdata = 32'(r_deb_div);
`endif
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge gpio_clock_i) begin
        if (gpio_reset_i) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_mask    <= '0;
        end else if (w_wr_en) begin
            case (w_word)
                REG_OUT:      r_out     <= (r_out & ~w_wl) | w_wb;
                REG_OUT_SET:  r_out     <= r_out | w_wb;
                REG_OUT_CLR:  r_out     <= r_out & ~w_wb;
                REG_OUT_TGL:  r_out     <= r_out ^ w_wb;
                REG_OE:       r_oe      <= (r_oe & ~w_wl) | w_wb;
                REG_RISE_EN:  r_rise_en <= (r_rise_en & ~w_wl) | w_wb;
                REG_FALL_EN:  r_fall_en <= (r_fall_en & ~w_wl) | w_wb;
                REG_IRQ_MASK: r_mask    <= (r_mask & ~w_wl) | w_wb;
                default: ;
            endcase
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    always_ff @(posedge gpio_clock_i) begin
        if (gpio_reset_i) begin
            r_deb_div <= DEB_DIV_RST;
        end else if (w_wr_en && w_word == REG_DEB_DIV) begin
            r_deb_div <= (r_deb_div & ~w_lanes[15:0]) | w_wbits[15:0];
        end
    end
`endif

    // Edges stay gated until the synchroniser has flushed the levels present at reset.
    assign w_edges = (r_quiet != 3'd0) ? '0 :
                     ((w_in & ~r_prev & r_rise_en) | (~w_in & r_prev & r_fall_en));

    always_ff @(posedge gpio_clock_i) begin
        if (gpio_reset_i) begin
            r_prev  <= '0;
            r_pend  <= '0;
            r_irq   <= 1'b0;
            r_quiet <= 3'(SYNC_STAGES + 1);
        end else begin
            r_prev <= w_in;
            r_pend <= (r_pend & ~w_w1c) | w_edges;
            r_irq  <= |(r_pend & r_mask);
            if (r_quiet != 3'd0) begin
                r_quiet <= r_quiet - 3'd1;
            end
        end
    end

    always_ff @(posedge gpio_clock_i) begin
        if (gpio_reset_i) begin
            r_d_valid  <= 1'b0;
            r_d_opcode <= ACCESS_ACK;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_denied <= 1'b0;
            r_d_data   <= '0;
        end else if (w_accept) begin
            r_d_valid  <= 1'b1;
            r_d_size   <= gpio_a_size;
            r_d_source <= gpio_a_source;
            if (w_is_get) begin
                r_d_opcode <= ACCESS_ACK_DATA;
                r_d_denied <= 1'b0;
                r_d_data   <= w_rdata;
            end else begin
                r_d_opcode <= ACCESS_ACK;
                r_d_denied <= ~w_is_put;
                r_d_data   <= '0;
            end
        end else if (gpio_d_ready) begin
            r_d_valid <= 1'b0;
        end
    end

    assign gpio_d_valid   = r_d_valid;
    assign gpio_d_opcode  = r_d_opcode;
    assign gpio_d_param   = 2'b00;
    assign gpio_d_size    = r_d_size;
    assign gpio_d_source  = r_d_source;
    assign gpio_d_denied  = r_d_denied;
    assign gpio_d_data    = r_d_data;
    assign gpio_d_corrupt = 1'b0;

    assign outputs_o = r_out;
    assign t_o       = ~r_oe;
    assign irq_o     = r_irq;

    assign w_unused = ^{gpio_a_param, gpio_a_corrupt, gpio_a_address[1:0], w_wbits, w_lanes};

endmodule

// File: tb/tb_polaris_gpio_v2.sv
// tb/tb_polaris_gpio_v2.sv - scoreboard bench for polaris_gpio_v2 (debounce steps need GPIO_DEBOUNCE_EN)
module tb_polaris_gpio_v2;

    logic        clk = 1'b0;
    logic        gpio_reset_i = 1'b1;
    logic [2:0]  gpio_a_opcode = '0;
    logic [2:0]  gpio_a_param = '0;
    logic [3:0]  gpio_a_size = '0;
    logic [3:0]  gpio_a_source = '0;
    logic [5:0]  gpio_a_address = '0;
    logic [3:0]  gpio_a_mask = '0;
    logic [31:0] gpio_a_data = '0;
    logic        gpio_a_corrupt = 1'b0;
    logic        gpio_a_valid = 1'b0;
    logic        gpio_a_ready;
    logic [2:0]  gpio_d_opcode;
    logic [1:0]  gpio_d_param;
    logic [3:0]  gpio_d_size;
    logic [3:0]  gpio_d_source;
    logic        gpio_d_denied;
    logic [31:0] gpio_d_data;
    logic        gpio_d_corrupt;
    logic        gpio_d_valid;
    logic        gpio_d_ready = 1'b1;
    logic [15:0] outputs_o;
    logic [15:0] t_o;
    logic [15:0] inputs_i = '0;
    logic        irq_o;

    typedef struct packed {
        logic [2:0]  opc;
        logic [3:0]  size;
        logic [3:0]  src;
        logic        den;
        logic [31:0] data;
        int          exp_edge;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          edges = 0;
    logic [3:0]  nsrc = 4'h0;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    polaris_gpio_v2 #(.TL_RS(4), .NGPIO(16), .SYNC_STAGES(2)) dut (
        .gpio_clock_i   (clk),
        .gpio_reset_i   (gpio_reset_i),
        .gpio_a_opcode  (gpio_a_opcode),
        .gpio_a_param   (gpio_a_param),
        .gpio_a_size    (gpio_a_size),
        .gpio_a_source  (gpio_a_source),
        .gpio_a_address (gpio_a_address),
        .gpio_a_mask    (gpio_a_mask),
        .gpio_a_data    (gpio_a_data),
        .gpio_a_corrupt (gpio_a_corrupt),
        .gpio_a_valid   (gpio_a_valid),
        .gpio_a_ready   (gpio_a_ready),
        .gpio_d_opcode  (gpio_d_opcode),
        .gpio_d_param   (gpio_d_param),
        .gpio_d_size    (gpio_d_size),
        .gpio_d_source  (gpio_d_source),
        .gpio_d_denied  (gpio_d_denied),
        .gpio_d_data    (gpio_d_data),
        .gpio_d_corrupt (gpio_d_corrupt),
        .gpio_d_valid   (gpio_d_valid),
        .gpio_d_ready   (gpio_d_ready),
        .outputs_o      (outputs_o),
        .t_o            (t_o),
        .inputs_i       (inputs_i),
        .irq_o          (irq_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic tl_req(input logic [2:0] op, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [3:0] src, input logic [31:0] rd_exp,
                          output int acc_edge);
        exp_t e;
        bit   acc;
        int   m;
        gpio_a_valid   = 1'b1;
        gpio_a_opcode  = op;
        gpio_a_address = addr;
        gpio_a_data    = data;
        gpio_a_mask    = mask;
        gpio_a_source  = src;
        gpio_a_size    = {2'b00, src[1:0]};
        acc_edge       = -1;
        for (int t = 0; t < 40 && acc_edge < 0; t++) begin
            @(negedge clk);
            acc = gpio_a_ready;
            m   = edges;
            @(posedge clk);
            if (acc) begin
                e.size     = {2'b00, src[1:0]};
                e.src      = src;
                e.exp_edge = m + 1;
                if (op == 3'd4) begin
                    e.opc = 3'd1; e.den = 1'b0; e.data = rd_exp;
                end else if (op == 3'd0 || op == 3'd1) begin
                    e.opc = 3'd0; e.den = 1'b0; e.data = 32'h0;
                end else begin
                    e.opc = 3'd0; e.den = 1'b1; e.data = 32'h0;
                end
                sb.push_back(e);
                acc_edge = m + 1;
            end
            #1;
        end
        gpio_a_valid = 1'b0;
        if (acc_edge < 0) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: addr 0x%0h never accepted", addr);
        end
    endtask

    task automatic get(input logic [5:0] addr, input logic [31:0] exp);
        int ae;
        tl_req(3'd4, addr, 32'h0, 4'hF, nsrc, exp, ae);
        nsrc++;
    endtask

    task automatic put(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] mask);
        int ae;
        tl_req(3'd0, addr, data, mask, nsrc, 32'h0, ae);
        nsrc++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && gpio_d_valid == 1'b0) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (gpio_d_valid !== 1'b1) begin
                seen = 0;
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: src 0x%0h data 0x%0h with empty scoreboard",
                         gpio_d_source, gpio_d_data);
            end else begin
                if (!seen) begin
                    chk("resp_latency", 64'(edges), 64'(sb[0].exp_edge));
                    seen = 1;
                end
                chk("d_fields",
                    64'({gpio_d_opcode, gpio_d_param, gpio_d_size, gpio_d_source,
                         gpio_d_denied, gpio_d_corrupt, gpio_d_data}),
                    64'({sb[0].opc, 2'b00, sb[0].size, sb[0].src, sb[0].den, 1'b0, sb[0].data}));
                if (gpio_d_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ae1, ae2, ae3;
        wait_cycles(3);
        gpio_reset_i = 1'b0;
        chk("reset_d_valid", 64'(gpio_d_valid), 64'd0);
        chk("reset_t_o", 64'(t_o), 64'hFFFF);
        chk("reset_irq", 64'(irq_o), 64'd0);
        chk("reset_outputs", 64'(outputs_o), 64'd0);
        chk("reset_a_ready", 64'(gpio_a_ready), 64'd1);
        get(6'h14, 32'h0);
        get(6'h04, 32'h0);

        put(6'h04, 32'h00F0, 4'hF);
        put(6'h08, 32'h000F, 4'hF);
        put(6'h0C, 32'h0030, 4'hF);
        put(6'h10, 32'h0101, 4'hF);
        wait_idle();
        chk("atomic_outputs", 64'(outputs_o), 64'h01CE);
        get(6'h08, 32'h0);
        get(6'h0C, 32'h0);
        get(6'h04, 32'h01CE);
        put(6'h14, 32'h00FF, 4'hF);
        wait_idle();
        chk("oe_t_o", 64'(t_o), 64'hFF00);
        get(6'h14, 32'h00FF);

        put(6'h04, 32'hFFFF, 4'b0010);
        get(6'h04, 32'hFFCE);
        tl_req(3'd2, 6'h04, 32'h0, 4'hF, 4'hB, 32'h0, ae1);
        get(6'h04, 32'hFFCE);
        put(6'h0C, 32'hFFFF, 4'b0001);
        get(6'h04, 32'hFF00);
        put(6'h04, 32'hFFFF_FFFF, 4'hF);
        get(6'h04, 32'h0000_FFFF);
        put(6'h04, 32'hFF00, 4'hF);
        put(6'h3C, 32'hFFFF, 4'hF);
        get(6'h30, 32'h0);
`ifdef GPIO_DEBOUNCE_EN
        get(6'h28, 32'h00FF);
`else
        get(6'h28, 32'h0);
`endif
        wait_idle();

`ifndef GPIO_DEBOUNCE_EN
        inputs_i = 16'h5A00;
        get(6'h00, 32'h0);
        get(6'h00, 32'h0);
        get(6'h00, 32'h5A00);
        wait_idle();

        put(6'h18, 32'h1, 4'hF);
        put(6'h24, 32'h1, 4'hF);
        wait_idle();
        inputs_i[0] = 1'b1;
        wait_cycles(3);
        chk("irq_before_latency", 64'(irq_o), 64'd0);
        wait_cycles(1);
        chk("irq_at_latency", 64'(irq_o), 64'd1);
        get(6'h20, 32'h1);
        put(6'h20, 32'h1, 4'hF);
        wait_idle();
        chk("irq_after_w1c", 64'(irq_o), 64'd0);
        get(6'h20, 32'h0);
        inputs_i[0] = 1'b0;
        wait_cycles(6);
        get(6'h20, 32'h0);
        wait_idle();
        inputs_i[0] = 1'b1;
        wait_cycles(2);
        put(6'h20, 32'h1, 4'hF);
        get(6'h20, 32'h1);
        wait_idle();
        chk("irq_set_wins", 64'(irq_o), 64'd1);
        put(6'h20, 32'h1, 4'hF);
        put(6'h1C, 32'h1, 4'hF);
        wait_idle();
        inputs_i[0] = 1'b0;
        wait_cycles(6);
        put(6'h1C, 32'h0, 4'hF);
        get(6'h20, 32'h1);
        get(6'h1C, 32'h0);
        put(6'h24, 32'h0, 4'hF);
        wait_idle();
        chk("irq_masked", 64'(irq_o), 64'd0);
        put(6'h20, 32'h1, 4'hF);
        get(6'h20, 32'h0);
        wait_idle();
`endif

        gpio_d_ready = 1'b0;
        tl_req(3'd4, 6'h04, 32'h0, 4'hF, 4'h5, 32'hFF00, ae1);
        for (int k = 0; k < 3; k++) begin
            chk("a_ready_stall", 64'(gpio_a_ready), 64'd0);
            wait_cycles(1);
        end
        gpio_d_ready = 1'b1;
        tl_req(3'd4, 6'h14, 32'h0, 4'hF, 4'h6, 32'h00FF, ae2);
        tl_req(3'd4, 6'h24, 32'h0, 4'hF, 4'h7, 32'h0, ae3);
        chk("back_to_back", 64'(ae3 - ae2), 64'd1);
        wait_idle();

        gpio_d_ready = 1'b0;
        tl_req(3'd4, 6'h14, 32'h0, 4'hF, 4'h9, 32'h00FF, ae1);
        gpio_reset_i = 1'b1;
        wait_cycles(1);
        chk("reset_drop_d_valid", 64'(gpio_d_valid), 64'd0);
        sb.delete();
        gpio_d_ready = 1'b1;
        inputs_i = '0;
        wait_cycles(2);
        gpio_reset_i = 1'b0;
        wait_cycles(2);
        chk("post_reset_d_valid", 64'(gpio_d_valid), 64'd0);
        chk("post_reset_t_o", 64'(t_o), 64'hFFFF);
        chk("post_reset_outputs", 64'(outputs_o), 64'd0);
        get(6'h04, 32'h0);
        get(6'h20, 32'h0);
        wait_idle();

`ifdef GPIO_DEBOUNCE_EN
        put(6'h28, 32'h3, 4'hF);
        put(6'h18, 32'h2, 4'hF);
        get(6'h28, 32'h3);
        wait_idle();
        wait_cycles(300);
        inputs_i[1] = 1'b1;
        wait_cycles(7);
        inputs_i[1] = 1'b0;
        wait_cycles(40);
        get(6'h00, 32'h0);
        get(6'h20, 32'h0);
        wait_idle();
        inputs_i[1] = 1'b1;
        wait_cycles(40);
        get(6'h00, 32'h2);
        get(6'h20, 32'h2);
        wait_idle();
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
